// File: rtl/uart_rx.sv
// 16-bit UART receiver: 1 start, 16 data (LSB first), 1 stop, no parity.
// Two-flop input synchroniser, mid-bit sampling, glitch and framing checks.
module uart_rx #(
    parameter int CLKS_PER_BIT = 435,
    parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [15:0] dout,
    output logic        done,
    output logic        active,
    output logic        frame_err
);

    localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP,
        S_BREAK
    } state_t;

    state_t      state;
    logic [1:0]  sync;
    logic [15:0] clk_cnt;
    logic [3:0]  bit_idx;
    logic [15:0] shreg;
    logic        rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= 2'b11;
            state     <= S_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            dout      <= '0;
            done      <= 1'b0;
            active    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], din};
            done      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        active <= 1'b1;
                        state  <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt == HALF_CNT) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state <= S_DATA;
                        end else begin
                            active <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt        <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 4'd15) begin
                            bit_idx <= '0;
                            state   <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt <= '0;
                        active  <= 1'b0;
                        if (rx_s) begin
                            dout  <= shreg;
                            done  <= 1'b1;
                            state <= S_CLEANUP;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                S_CLEANUP: begin
                    state <= S_IDLE;
                end
                // A line held low after a bad stop bit must not start frames.
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    active  <= 1'b0;
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: reset, frames, glitch, framing error,
// back-to-back frames and reset in the middle of a frame.
module tb_uart_rx;

    localparam int CPB = 435;

    logic        clk;
    logic        rst;
    logic        din;
    logic [15:0] dout;
    logic        done;
    logic        active;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          done_cnt = 0;
    int          ferr_cnt = 0;
    int          bad_cnt = 0;
    int          rise_cnt = 0;
    int          act_rise = 0;
    int          act_fall = 0;
    logic        prev_active = 1'b0;
    int          done_cyc[$];
    logic [15:0] done_val[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .HALF_BIT((CPB - 1) / 2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .dout(dout),
        .done(done),
        .active(active),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and edge recorder; sampled half a clock away from the DUT edge.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc.push_back(cyc);
            done_val.push_back(dout);
        end
        if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (done === 1'b1 && frame_err === 1'b1) bad_cnt = bad_cnt + 1;
        if ((done === 1'b1 || frame_err === 1'b1) && active !== 1'b0)
            bad_cnt = bad_cnt + 1;
        if (active === 1'b1 && prev_active !== 1'b1) begin
            act_rise = cyc;
            rise_cnt = rise_cnt + 1;
        end
        if (active === 1'b0 && prev_active === 1'b1) act_fall = cyc;
        prev_active = active;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        din = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Call at a negedge; returns the cycle of the start edge.
    task automatic send_frame(input logic [15:0] w, input logic stop,
                              output int fall);
        fall = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 16; i++) send_bit(w[i]);
        send_bit(stop);
    endtask

    task automatic test_reset;
        int d0;
        int f0;
        rst = 1'b1;
        din = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        checks++;
        if (dout !== 16'h0000) begin
            errors++;
            $display("FAIL reset_dout: got %h expected 0000", dout);
        end
        checks++;
        if (done !== 1'b0 || active !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got done=%b active=%b ferr=%b expected 0 0 0",
                     done, active, frame_err);
        end
        d0 = done_cnt;
        f0 = ferr_cnt;
        idle(1000);
        checks++;
        if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0 || rise_cnt !== 0) begin
            errors++;
            $display("FAIL reset_idle: got done=%0d ferr=%0d rises=%0d expected 0 0 0",
                     done_cnt - d0, ferr_cnt - f0, rise_cnt);
        end
    endtask

    task automatic test_single_frame;
        int d0;
        int fall;
        int lat;
        d0 = done_cnt;
        send_frame(16'hA5C3, 1'b1, fall);
        idle(100);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d expected 1", done_cnt - d0);
        end else begin
            lat = done_cyc[d0] - fall;
            checks++;
            if (lat < 7615 || lat > 7617) begin
                errors++;
                $display("FAIL single_latency: got %0d expected 7616", lat);
            end
            checks++;
            if (done_val[d0] !== 16'hA5C3) begin
                errors++;
                $display("FAIL single_dout: got %h expected a5c3", done_val[d0]);
            end
        end
        checks++;
        if (act_rise - fall !== 3) begin
            errors++;
            $display("FAIL single_active_rise: got %0d expected 3", act_rise - fall);
        end
        checks++;
        if (act_fall - fall !== 7616) begin
            errors++;
            $display("FAIL single_active_fall: got %0d expected 7616", act_fall - fall);
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        int fa;
        int fb;
        int gap;
        d0 = done_cnt;
        send_frame(16'h0000, 1'b1, fa);
        send_frame(16'hFFFF, 1'b1, fb);
        idle(100);
        checks++;
        if (done_cnt - d0 !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 2", done_cnt - d0);
        end else begin
            gap = done_cyc[d0 + 1] - done_cyc[d0];
            checks++;
            if (gap < 7829 || gap > 7831) begin
                errors++;
                $display("FAIL b2b_gap: got %0d expected 7830", gap);
            end
            checks++;
            if (done_val[d0] !== 16'h0000) begin
                errors++;
                $display("FAIL b2b_first: got %h expected 0000", done_val[d0]);
            end
            checks++;
            if (done_val[d0 + 1] !== 16'hFFFF) begin
                errors++;
                $display("FAIL b2b_second: got %h expected ffff", done_val[d0 + 1]);
            end
        end
    endtask

    task automatic test_glitch;
        int d0;
        int f0;
        int fall;
        int unused;
        d0 = done_cnt;
        f0 = ferr_cnt;
        fall = cyc;
        din = 1'b0;
        idle(100);
        din = 1'b1;
        idle(300);
        checks++;
        if (act_rise - fall !== 3 || act_fall - fall !== 221) begin
            errors++;
            $display("FAIL glitch_active: got rise=%0d fall=%0d expected 3 221",
                     act_rise - fall, act_fall - fall);
        end
        checks++;
        if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin
            errors++;
            $display("FAIL glitch_pulses: got done=%0d ferr=%0d expected 0 0",
                     done_cnt - d0, ferr_cnt - f0);
        end
        send_frame(16'h1234, 1'b1, unused);
        idle(100);
        checks++;
        if (done_cnt - d0 !== 1 || dout !== 16'h1234) begin
            errors++;
            $display("FAIL glitch_next: got count=%0d dout=%h expected 1 1234",
                     done_cnt - d0, dout);
        end
    endtask

    task automatic test_frame_error;
        int d0;
        int f0;
        int r0;
        int unused;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(16'h5555, 1'b0, unused);
        r0 = rise_cnt;
        idle(5000);
        checks++;
        if (ferr_cnt - f0 !== 1 || done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL ferr_pulses: got ferr=%0d done=%0d expected 1 0",
                     ferr_cnt - f0, done_cnt - d0);
        end
        checks++;
        if (dout !== 16'h1234) begin
            errors++;
            $display("FAIL ferr_dout: got %h expected 1234", dout);
        end
        checks++;
        if (rise_cnt !== r0 || active !== 1'b0) begin
            errors++;
            $display("FAIL ferr_hold: got rises=%0d active=%b expected 0 0",
                     rise_cnt - r0, active);
        end
        din = 1'b1;
        idle(1000);
        checks++;
        if (rise_cnt !== r0 || done_cnt - d0 !== 0 || ferr_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL ferr_release: got rises=%0d done=%0d ferr=%0d expected 0 0 1",
                     rise_cnt - r0, done_cnt - d0, ferr_cnt - f0);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] w;
        int d0;
        int f0;
        int unused;
        w = 16'hBEEF;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        din = w[7];
        idle(200);
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got active=%b expected 1", active);
        end
        rst = 1'b1;
        din = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL midrst_active: got %b expected 0", active);
        end
        idle(1000);
        checks++;
        if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0 || dout !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_pulses: got done=%0d ferr=%0d dout=%h expected 0 0 0000",
                     done_cnt - d0, ferr_cnt - f0, dout);
        end
        send_frame(16'h1357, 1'b1, unused);
        idle(100);
        checks++;
        if (done_cnt - d0 !== 1 || dout !== 16'h1357) begin
            errors++;
            $display("FAIL midrst_next: got count=%0d dout=%h expected 1 1357",
                     done_cnt - d0, dout);
        end
    endtask

    task automatic test_invariants;
        checks++;
        if (bad_cnt !== 0) begin
            errors++;
            $display("FAIL invariants: got %0d violations expected 0", bad_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b1;
        @(negedge clk);
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_reset_mid_frame;
        test_invariants;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
